// File: rtl/cube_move_pkg.sv
// Shared constants for the cube move scheduler: face codes, button bit
// positions, move-code layout and the button-to-face map.
package cube_move_pkg;

    localparam logic [2:0] FACE_FRONT = 3'd0;
    localparam logic [2:0] FACE_BACK  = 3'd1;
    localparam logic [2:0] FACE_UP    = 3'd2;
    localparam logic [2:0] FACE_DOWN  = 3'd3;
    localparam logic [2:0] FACE_LEFT  = 3'd4;
    localparam logic [2:0] FACE_RIGHT = 3'd5;

    // Button vectors are ordered {C,L,U,R,D}, so D is bit 0.
    localparam int unsigned BTN_D   = 0;
    localparam int unsigned BTN_R   = 1;
    localparam int unsigned BTN_U   = 2;
    localparam int unsigned BTN_L   = 3;
    localparam int unsigned BTN_C   = 4;
    localparam int unsigned NUM_BTN = 5;

    localparam int unsigned MC_W        = 4;
    localparam int unsigned MC_CCW      = 3;
    localparam int unsigned MC_FACE_MSB = 2;
    localparam int unsigned MC_FACE_LSB = 0;

    function automatic logic [2:0] btn_face(input logic [2:0] idx);
        logic [2:0] face;
        face = FACE_FRONT;
        case (idx)
            3'(BTN_C): face = FACE_FRONT;
            3'(BTN_U): face = FACE_UP;
            3'(BTN_D): face = FACE_DOWN;
            3'(BTN_L): face = FACE_LEFT;
            3'(BTN_R): face = FACE_RIGHT;
            default:   face = FACE_FRONT;
        endcase
        return face;
    endfunction

endpackage

// File: rtl/cube_move_sched_fifo.sv
// First-word fall-through FIFO for move codes; accepts a write while full
// when the head is popped in the same cycle.
module move_fifo
    import cube_move_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [MC_W-1:0]  wr_data,
    input  logic             rd_en,
    output logic [MC_W-1:0]  rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [MC_W-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_wr;
    logic            do_rd;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

endmodule

// File: rtl/cube_move_sched.sv
// Merges on-board and PMOD move buttons into one ordered move queue:
// edge detect, pending/prime store, round-robin grant into move_fifo.
module cube_move_sched
    import cube_move_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic             SI_ClkIn,
    input  logic             SI_Reset_N,
    input  logic             enable,
    input  logic             flush,
    input  logic [4:0]       pb_btn,
    input  logic             pb_prime,
    input  logic [4:0]       pmod_btn,
    input  logic             pmod_prime,
    input  logic             move_pop,
    output logic             move_valid,
    output logic [3:0]       move_code,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);

    logic [4:0]       pb_prev;
    logic [4:0]       pmod_prev;
    logic [1:0][4:0]  pend;
    logic [1:0][4:0]  prime;
    logic [1:0][4:0]  edge_v;
    logic [1:0][4:0]  drop_v;
    logic [1:0][4:0]  set_v;
    logic [1:0][4:0]  gnt_mask;
    logic [1:0][4:0]  prime_nxt;
    logic [1:0]       prime_in;
    logic             rr_ptr;
    logic             gnt_src;
    logic             gnt_vld;
    logic [2:0]       gnt_idx;
    logic [MC_W-1:0]  wr_code;
    logic             fifo_full;
    logic             fifo_empty;
    logic             space;
    logic [3:0]       drop_num;
    logic [8:0]       drop_sum;

    function automatic logic [2:0] pick(input logic [4:0] p);
        logic [2:0] idx;
        idx = 3'(BTN_C);
        if      (p[BTN_U]) idx = 3'(BTN_U);
        else if (p[BTN_D]) idx = 3'(BTN_D);
        else if (p[BTN_L]) idx = 3'(BTN_L);
        else if (p[BTN_R]) idx = 3'(BTN_R);
        return idx;
    endfunction

    assign edge_v   = {pmod_btn & ~pmod_prev, pb_btn & ~pb_prev};
    assign prime_in = {pmod_prime, pb_prime};

    always_comb begin
        space    = !fifo_full || move_pop;
        gnt_src  = (|pend[0] && |pend[1]) ? rr_ptr : |pend[1];
        gnt_vld  = (|pend) && space && enable && !flush;
        gnt_idx  = pick(pend[gnt_src]);
        gnt_mask = '0;
        if (gnt_vld) gnt_mask[gnt_src][gnt_idx] = 1'b1;
        wr_code  = {prime[gnt_src][gnt_idx], btn_face(gnt_idx)};

        drop_v    = '0;
        set_v     = '0;
        prime_nxt = prime;
        // A bit granted this cycle is free again, so a new edge on it is a fresh request.
        if (enable && !flush) begin
            for (int unsigned s = 0; s < 2; s++) begin
                drop_v[s]    = edge_v[s] & pend[s] & ~gnt_mask[s];
                set_v[s]     = edge_v[s] & ~drop_v[s];
                prime_nxt[s] = (prime[s] & ~set_v[s]) | (set_v[s] & {5{prime_in[s]}});
            end
        end
        drop_num = 4'($countones(drop_v));
        drop_sum = {1'b0, drop_cnt} + 9'(drop_num);
    end

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            pb_prev   <= '1;
            pmod_prev <= '1;
            pend      <= '0;
            prime     <= '0;
            rr_ptr    <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            pb_prev   <= pb_btn;
            pmod_prev <= pmod_btn;
            if (flush || !enable) begin
                pend  <= '0;
                prime <= '0;
            end else begin
                pend  <= (pend & ~gnt_mask) | edge_v;
                prime <= prime_nxt;
            end
            if (gnt_vld) rr_ptr <= ~gnt_src;
            if (|drop_v) overflow <= 1'b1;
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    move_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (SI_ClkIn),
        .rst_n   (SI_Reset_N),
        .flush   (flush),
        .wr_en   (gnt_vld),
        .wr_data (wr_code),
        .rd_en   (move_pop),
        .rd_data (move_code),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign move_valid = !fifo_empty;

endmodule

// File: tb/tb_cube_move_sched.sv
// Directed self-checking bench for cube_move_sched.
module tb_cube_move_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       flush;
    logic [4:0] pb_btn;
    logic       pb_prime;
    logic [4:0] pmod_btn;
    logic       pmod_prime;
    logic       move_pop;
    logic       move_valid;
    logic [3:0] move_code;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    cube_move_sched #(
        .FIFO_DEPTH (4),
        .CNT_W      (3)
    ) dut (
        .SI_ClkIn   (clk),
        .SI_Reset_N (rst_n),
        .enable     (enable),
        .flush      (flush),
        .pb_btn     (pb_btn),
        .pb_prime   (pb_prime),
        .pmod_btn   (pmod_btn),
        .pmod_prime (pmod_prime),
        .move_pop   (move_pop),
        .move_valid (move_valid),
        .move_code  (move_code),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] pb_hold);
        rst_n = 1'b0; enable = 1'b1; flush = 1'b0;
        pb_btn = pb_hold; pb_prime = 1'b0;
        pmod_btn = '0; pmod_prime = 1'b0; move_pop = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; flush = 1'b0;
        pb_btn = 5'b00100; pb_prime = 1'b0;
        pmod_btn = '0; pmod_prime = 1'b0; move_pop = 1'b0;
        tick();
        total++;
        if ({move_valid, move_code, fifo_count, overflow, drop_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_vals: got v=%b c=%h n=%0d o=%b d=%0d want all 0",
                     move_valid, move_code, fifo_count, overflow, drop_cnt);
        end
        rst_n = 1'b1;
        repeat (4) tick();
        total++;
        if (move_valid !== 1'b0 || fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL held_through_reset: got v=%b n=%0d want v=0 n=0", move_valid, fifo_count);
        end
        pb_btn = 5'b00000;
        tick();
        pb_btn = 5'b00100;
        tick();
        total++;
        if (move_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: got v=%b want 0", move_valid);
        end
        tick();
        total++;
        if (move_valid !== 1'b1 || move_code !== 4'h2) begin
            bad++;
            $display("FAIL latency_u: got v=%b c=%h want v=1 c=2", move_valid, move_code);
        end
        move_pop = 1'b1;
        tick();
        move_pop = 1'b0;
        pb_btn = '0;
        total++;
        if (fifo_count !== 3'd0 || move_valid !== 1'b0) begin
            bad++;
            $display("FAIL pop_empty: got n=%0d v=%b want n=0 v=0", fifo_count, move_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset('0);
        pb_btn = 5'b00100; pmod_btn = 5'b01000; pmod_prime = 1'b1;
        repeat (3) tick();
        total++;
        if (fifo_count !== 3'd2 || move_code !== 4'h2) begin
            bad++;
            $display("FAIL rr_first: got n=%0d c=%h want n=2 c=2", fifo_count, move_code);
        end
        move_pop = 1'b1;
        tick();
        move_pop = 1'b0;
        total++;
        if (fifo_count !== 3'd1 || move_code !== 4'hC) begin
            bad++;
            $display("FAIL rr_second: got n=%0d c=%h want n=1 c=C", fifo_count, move_code);
        end
        move_pop = 1'b1;
        tick();
        move_pop = 1'b0;
        pb_btn = '0; pmod_btn = '0; pmod_prime = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [3:0] order [4];
        order[0] = 4'h3; order[1] = 4'h4; order[2] = 4'h5; order[3] = 4'h0;
        do_reset('0);
        pb_btn = 5'b11111;
        repeat (7) tick();
        total++;
        if (fifo_count !== 3'd4 || move_code !== 4'h2) begin
            bad++;
            $display("FAIL bp_full: got n=%0d c=%h want n=4 c=2", fifo_count, move_code);
        end
        move_pop = 1'b1;
        tick();
        move_pop = 1'b0;
        total++;
        if (fifo_count !== 3'd4) begin
            bad++;
            $display("FAIL bp_pop_through: got n=%0d want 4", fifo_count);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (move_code !== order[i]) begin
                bad++;
                $display("FAIL bp_order%0d: got %h want %h", i, move_code, order[i]);
            end
            move_pop = 1'b1;
            tick();
            move_pop = 1'b0;
        end
        total++;
        if (fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL bp_drained: got n=%0d want 0", fifo_count);
        end
        pb_btn = '0;
    endtask

    task automatic test_overflow();
        do_reset('0);
        pb_btn = 5'b11111;
        repeat (7) tick();
        pb_btn = 5'b00000;
        tick();
        pb_btn = 5'b00001;
        tick();
        total++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL ovf_first_press: got o=%b d=%0d want o=0 d=0", overflow, drop_cnt);
        end
        pb_btn = 5'b00000;
        tick();
        pb_btn = 5'b00001;
        tick();
        total++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            bad++;
            $display("FAIL ovf_drop1: got o=%b d=%0d want o=1 d=1", overflow, drop_cnt);
        end
        for (int i = 0; i < 299; i++) begin
            pb_btn = 5'b00000;
            tick();
            pb_btn = 5'b00001;
            tick();
        end
        total++;
        if (drop_cnt !== 8'd255 || fifo_count !== 3'd4) begin
            bad++;
            $display("FAIL ovf_saturate: got d=%0d n=%0d want d=255 n=4", drop_cnt, fifo_count);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({move_valid, move_code, fifo_count, overflow, drop_cnt} !== '0) begin
            bad++;
            $display("FAIL async_reset: got v=%b c=%h n=%0d o=%b d=%0d want all 0",
                     move_valid, move_code, fifo_count, overflow, drop_cnt);
        end
        pb_btn = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_enable_flush();
        do_reset('0);
        enable = 1'b0;
        pb_btn = 5'b00100;
        tick();
        pb_btn = 5'b00000;
        tick();
        pb_btn = 5'b00100;
        repeat (3) tick();
        total++;
        if (fifo_count !== 3'd0 || move_valid !== 1'b0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL disabled: got n=%0d v=%b d=%0d o=%b want 0", fifo_count, move_valid, drop_cnt, overflow);
        end
        pb_btn = 5'b00000;
        enable = 1'b1;
        tick();
        pb_btn = 5'b01101;
        repeat (5) tick();
        total++;
        if (fifo_count !== 3'd3 || move_code !== 4'h2) begin
            bad++;
            $display("FAIL fill3: got n=%0d c=%h want n=3 c=2", fifo_count, move_code);
        end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        total++;
        if (fifo_count !== 3'd3) begin
            bad++;
            $display("FAIL disable_retain: got n=%0d want 3", fifo_count);
        end
        pb_btn = 5'b01111;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (fifo_count !== 3'd0 || move_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush: got n=%0d v=%b want n=0 v=0", fifo_count, move_valid);
        end
        repeat (3) tick();
        total++;
        if (fifo_count !== 3'd0 || drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL flush_pending: got n=%0d d=%0d want n=0 d=0", fifo_count, drop_cnt);
        end
        pb_btn = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_async_reset();
        test_enable_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
